fft8_input_deserializer: RTL and testbench
==========================================

Name: fft8_input_deserializer

Overview:
- Serial-to-parallel front end for the 8-point FFT datapath.
- Accepts one complex sample per handshake (32-bit real, 32-bit imaginary) and fills eight parallel bin registers, X0r/X0i through X7r/X7i.
- Presents the full frame to the FFT core with a valid/ack handshake.
- Performs the inverse function of the output-side bin selector, which serialises FFT results.

Parameters:
- DATA_W, 32, width of each real and each imaginary component.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input sample present.
- in_ready  output  1  block can accept a sample this cycle.
- in_sof  input  1  start-of-frame marker, qualified by in_valid.
- in_real  input  DATA_W  sample real part.
- in_img  input  DATA_W  sample imaginary part.
- frame_valid  output  1  eight samples held on X* outputs.
- frame_ack  input  1  FFT core consumed the frame.
- sync_err  output  1  one-cycle pulse when a partial frame was discarded.
- X0r,X0i ... X7r,X7i  output  DATA_W each  registered frame bins, k = 0..7.

Behaviour:
- Reset:
  - State = FILL; cnt = 0.
  - frame_valid = 0; sync_err = 0.
  - All X* registers = 0.
  - in_ready = 1 on the first cycle after reset.
- States: FILL (collecting; cnt = 0..7) and FULL (frame presented).
- in_ready = (state == FILL) || frame_ack. The FULL state is combinationally released by ack.
- Accept = in_valid && in_ready.
- On accept, the sample is written to bin index idx(cnt):
  - X{idx}r <= in_real; X{idx}i <= in_img.
  - Other bins hold their values.
- Counter and state updates:
  - cnt increments on accept.
  - cnt == 7 on accept → cnt <= 0, state <= FULL, frame_valid <= 1 on the next cycle.
  - Latency: 8th sample accepted at edge N → frame_valid = 1 after edge N.
- FULL:
  - X* outputs are stable and frame_valid = 1 until frame_ack is sampled high.
  - frame_ack high → frame_valid <= 0, state <= FILL.
  - If in_valid is also high that cycle, the sample is accepted as bin idx(0) of the next frame. This allows zero-bubble back-to-back frames.
- frame_ack while in FILL: ignored.
- in_sof handling on accept:
  - in_sof with cnt == 0: normal.
  - in_sof with cnt != 0: the partial frame is discarded. The sample is written as idx(0), cnt <= 1, and sync_err pulses high for one cycle (registered).
  - Stale bins from the discarded partial frame are overwritten as the new frame fills; they are not cleared.
  - in_sof with cnt == 0 in FILL after the previous frame was acked: normal, no error.
- Samples without in_sof are never rejected; frame alignment is purely count-based unless in_sof resynchronises.
- rst mid-frame or while FULL: immediate return to reset values; a partial or pending frame is lost with no sync_err.
- No arithmetic is performed. Data passes unmodified at DATA_W bits.

Optional Feature:
- Macro: FFT8_BITREV_EN.
- Defined: idx(cnt) = 3-bit bit-reverse of cnt (0,4,2,6,1,5,3,7), i.e. input ordering for the decimation-in-time FFT core.
- Undefined: idx(cnt) = cnt (natural order).
- Handshake, latency and sync_err behaviour are identical in both builds.

Decomposition:
- Shared package fft8_pkg holds:
  - FFT8_N = 8; FFT8_IDX_W = 3; default DATA_W = 32.
  - A state typedef {FILL, FULL}.
  - A bitrev3 function, also usable by the output-side selector.
- One natural sub-module: fft8_bin_regfile. It holds the 8×2 registers with write enable plus a 3-bit write index, and exposes the flat X* outputs.
- Control (counter, FSM, handshake, sync_err) stays in the top module.

Test Plan:
- Reset then 8 accepted samples, real=k+1, img=-(k+1) for k = 0..7 (sof on k=0) → frame_valid high the cycle after the 8th accept. Natural build: X3r=4, X3i=-4. BITREV build: X4r=2, X4i=-2.
- Hold frame_ack low for 5 cycles with in_valid high → in_ready=0 throughout and X* unchanged. Then pulse frame_ack with a valid sample 0x11 → frame_valid drops and 0x11 lands in X0r. No bubble.
- Accept 3 samples, then a sample 0xAA with in_sof → sync_err pulses exactly one cycle, cnt restarts, and the frame completes after 7 further samples with X0r=0xAA.
- Assert rst after 5 accepted samples → all X*=0, frame_valid=0, and a new 8-sample frame completes normally.
- Random in_valid gaps (~50%) over 4 frames with random ack delays 0–3 → every output frame matches the golden model, and no sample is dropped or duplicated.
- frame_ack pulsed during FILL at cnt=2 → ignored; frame completes after 6 more accepts.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared types, sizes and index helpers for the 8-point FFT front/back ends.
package fft8_pkg;

  localparam int FFT8_N      = 8;
  localparam int FFT8_IDX_W  = 3;
  localparam int FFT8_DATA_W = 32;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fft8_state_e;

  function automatic logic [FFT8_IDX_W-1:0] bitrev3(input logic [FFT8_IDX_W-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft8_bin_regfile.sv
// Eight complex bin registers with a single indexed write port; exposes flat X* outputs.
module fft8_bin_regfile
  import fft8_pkg::*;
#(
  parameter int DATA_W = FFT8_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [FFT8_IDX_W-1:0] widx_i,
  input  logic [DATA_W-1:0]     wr_real_i,
  input  logic [DATA_W-1:0]     wr_img_i,
  output logic [DATA_W-1:0]     X0r,
  output logic [DATA_W-1:0]     X0i,
  output logic [DATA_W-1:0]     X1r,
  output logic [DATA_W-1:0]     X1i,
  output logic [DATA_W-1:0]     X2r,
  output logic [DATA_W-1:0]     X2i,
  output logic [DATA_W-1:0]     X3r,
  output logic [DATA_W-1:0]     X3i,
  output logic [DATA_W-1:0]     X4r,
  output logic [DATA_W-1:0]     X4i,
  output logic [DATA_W-1:0]     X5r,
  output logic [DATA_W-1:0]     X5i,
  output logic [DATA_W-1:0]     X6r,
  output logic [DATA_W-1:0]     X6i,
  output logic [DATA_W-1:0]     X7r,
  output logic [DATA_W-1:0]     X7i
);

  logic [DATA_W-1:0] re_q [FFT8_N];
  logic [DATA_W-1:0] im_q [FFT8_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FFT8_N; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (we_i) begin
      re_q[widx_i] <= wr_real_i;
      im_q[widx_i] <= wr_img_i;
    end
  end

  assign X0r = re_q[0];
  assign X0i = im_q[0];
  assign X1r = re_q[1];
  assign X1i = im_q[1];
  assign X2r = re_q[2];
  assign X2i = im_q[2];
  assign X3r = re_q[3];
  assign X3i = im_q[3];
  assign X4r = re_q[4];
  assign X4i = im_q[4];
  assign X5r = re_q[5];
  assign X5i = im_q[5];
  assign X6r = re_q[6];
  assign X6i = im_q[6];
  assign X7r = re_q[7];
  assign X7i = im_q[7];

endmodule

// File: rtl/fft8_input_deserializer.sv
// Serial-to-parallel front end: gathers 8 complex samples into bins, presents them with valid/ack.
// Define FFT8_BITREV_EN to store samples in bit-reversed bin order instead of natural order.
module fft8_input_deserializer
  import fft8_pkg::*;
#(
  parameter int DATA_W = FFT8_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_img,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              sync_err,
  output logic [DATA_W-1:0] X0r,
  output logic [DATA_W-1:0] X0i,
  output logic [DATA_W-1:0] X1r,
  output logic [DATA_W-1:0] X1i,
  output logic [DATA_W-1:0] X2r,
  output logic [DATA_W-1:0] X2i,
  output logic [DATA_W-1:0] X3r,
  output logic [DATA_W-1:0] X3i,
  output logic [DATA_W-1:0] X4r,
  output logic [DATA_W-1:0] X4i,
  output logic [DATA_W-1:0] X5r,
  output logic [DATA_W-1:0] X5i,
  output logic [DATA_W-1:0] X6r,
  output logic [DATA_W-1:0] X6i,
  output logic [DATA_W-1:0] X7r,
  output logic [DATA_W-1:0] X7i
);

  fft8_state_e           state_q, state_d;
  logic [FFT8_IDX_W-1:0] cnt_q, cnt_d;
  logic                  sync_err_q, sync_err_d;
  logic                  accept;
  logic [FFT8_IDX_W-1:0] wcnt;
  logic [FFT8_IDX_W-1:0] widx;

  // A pending frame is released in the same cycle its ack arrives, so a new frame can start bubble-free.
  assign in_ready    = (state_q == FILL) || frame_ack;
  assign accept      = in_valid && in_ready;
  assign frame_valid = (state_q == FULL);
  assign sync_err    = sync_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = 1'b0;
    wcnt       = cnt_q;

    if (state_q == FULL && frame_ack) begin
      state_d = FILL;
    end

    if (accept) begin
      if (in_sof && cnt_q != '0) begin
        // Resync: this sample becomes slot 0 of a fresh frame; stale bins are left to be overwritten.
        wcnt       = '0;
        cnt_d      = 3'd1;
        sync_err_d = 1'b1;
      end else if (cnt_q == 3'(FFT8_N - 1)) begin
        cnt_d   = '0;
        state_d = FULL;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

`ifdef FFT8_BITREV_EN
  assign widx = bitrev3(wcnt);
`else
  assign widx = wcnt;
`endif

  fft8_bin_regfile #(
    .DATA_W(DATA_W)
  ) u_bins (
    .clk       (clk),
    .rst       (rst),
    .we_i      (accept),
    .widx_i    (widx),
    .wr_real_i (in_real),
    .wr_img_i  (in_img),
    .X0r       (X0r),
    .X0i       (X0i),
    .X1r       (X1r),
    .X1i       (X1i),
    .X2r       (X2r),
    .X2i       (X2i),
    .X3r       (X3r),
    .X3i       (X3i),
    .X4r       (X4r),
    .X4i       (X4i),
    .X5r       (X5r),
    .X5i       (X5i),
    .X6r       (X6r),
    .X6i       (X6i),
    .X7r       (X7r),
    .X7i       (X7i)
  );

endmodule

// File: tb/tb_fft8_input_deserializer.sv
// Directed plus randomized bench for fft8_input_deserializer against a frame-level reference model.
module tb_fft8_input_deserializer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_sof, frame_ack;
  logic [W-1:0] in_real, in_img;
  logic         in_ready, frame_valid, sync_err;
  logic [W-1:0] X0r, X0i, X1r, X1i, X2r, X2i, X3r, X3i;
  logic [W-1:0] X4r, X4i, X5r, X5i, X6r, X6i, X7r, X7i;
  logic [W-1:0] xr [8];
  logic [W-1:0] xi [8];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit           m_full;
  int           m_cnt;
  bit           m_err;
  logic [W-1:0] m_re [8];
  logic [W-1:0] m_im [8];
  int           slot_of [8];

  always #5 clk = ~clk;

  fft8_input_deserializer #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_real(in_real), .in_img(in_img), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .sync_err(sync_err),
    .X0r(X0r), .X0i(X0i), .X1r(X1r), .X1i(X1i), .X2r(X2r), .X2i(X2i), .X3r(X3r), .X3i(X3i),
    .X4r(X4r), .X4i(X4i), .X5r(X5r), .X5i(X5i), .X6r(X6r), .X6i(X6i), .X7r(X7r), .X7i(X7i)
  );

  assign xr[0] = X0r; assign xi[0] = X0i; assign xr[1] = X1r; assign xi[1] = X1i;
  assign xr[2] = X2r; assign xi[2] = X2i; assign xr[3] = X3r; assign xi[3] = X3i;
  assign xr[4] = X4r; assign xi[4] = X4i; assign xr[5] = X5r; assign xi[5] = X5i;
  assign xr[6] = X6r; assign xi[6] = X6i; assign xr[7] = X7r; assign xi[7] = X7i;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_cnt  = 0;
    m_err  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m_re[k] = '0;
      m_im[k] = '0;
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ":frame_valid"}, W'(frame_valid), W'(m_full));
    chk({where, ":sync_err"}, W'(sync_err), W'(m_err));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s:X%0dr", where, k), xr[k], m_re[k]);
      chk($sformatf("%s:X%0di", where, k), xi[k], m_im[k]);
    end
  endtask

  // One clock: drive at negedge, check ready, let the edge pass, update model, check outputs.
  task automatic step(input string where, input bit v, input bit sof,
                      input logic [W-1:0] re, input logic [W-1:0] im, input bit ack,
                      output bit acc);
    bit exp_ready;
    in_valid  = v;
    in_sof    = sof;
    in_real   = re;
    in_img    = im;
    frame_ack = ack;
    #1;
    exp_ready = !m_full || ack;
    chk({where, ":in_ready"}, W'(in_ready), W'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    m_err = 1'b0;
    if (m_full && ack) m_full = 1'b0;
    if (acc) begin
      if (sof && m_cnt != 0) begin
        m_re[slot_of[0]] = re;
        m_im[slot_of[0]] = im;
        m_cnt = 1;
        m_err = 1'b1;
      end else begin
        m_re[slot_of[m_cnt]] = re;
        m_im[slot_of[m_cnt]] = im;
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt  = 0;
          m_full = 1'b1;
        end
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    frame_ack = 1'b0;
    check_outputs(where);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    frame_ack = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs("reset");
    #1;
    chk("reset:in_ready", W'(in_ready), W'(1));
  endtask

  initial begin
    bit acc;
    logic [W-1:0] samples [$];
    int sent, frames_seen, delay, cyc;
    bit v, prev_fv;
`ifdef FFT8_BITREV_EN
    slot_of = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    slot_of = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    in_real = '0;
    in_img  = '0;
    @(negedge clk);
    apply_reset();

    // first frame: real=k+1, img=-(k+1)
    for (int k = 0; k < 8; k++) begin
      int nv;
      nv = -(k + 1);
      step("frame1", 1'b1, k == 0, W'(k + 1), W'(nv), 1'b0, acc);
    end
    chk("frame1:fv_after_8th", W'(frame_valid), W'(1));
`ifdef FFT8_BITREV_EN
    chk("frame1:X4r", X4r, 32'd2);
    chk("frame1:X4i", X4i, 32'hFFFF_FFFE);
`else
    chk("frame1:X3r", X3r, 32'd4);
    chk("frame1:X3i", X3i, 32'hFFFF_FFFC);
`endif

    // held frame with upstream pressure
    for (int k = 0; k < 5; k++) step("hold", 1'b1, 1'b0, 32'hDEAD_0000 + W'(k), 32'h1, 1'b0, acc);
    step("ack_b2b", 1'b1, 1'b1, 32'h11, 32'h22, 1'b1, acc);
    chk("ack_b2b:accepted", W'(acc), W'(1));
    chk("ack_b2b:fv_drop", W'(frame_valid), W'(0));
    chk("ack_b2b:X0r", X0r, 32'h11);

    // resync after 3 accepted samples
    step("partial", 1'b1, 1'b0, 32'h21, 32'h31, 1'b0, acc);
    step("partial", 1'b1, 1'b0, 32'h22, 32'h32, 1'b0, acc);
    step("resync", 1'b1, 1'b1, 32'hAA, 32'hBB, 1'b0, acc);
    chk("resync:sync_err_pulse", W'(sync_err), W'(1));
    for (int k = 1; k < 8; k++) begin
      step("resync_fill", 1'b1, 1'b0, 32'h40 + W'(k), 32'h50 + W'(k), 1'b0, acc);
      if (k == 1) chk("resync:sync_err_one_cycle", W'(sync_err), W'(0));
    end
    chk("resync:fv", W'(frame_valid), W'(1));
    chk("resync:X0r", X0r, 32'hAA);
    step("resync_ack", 1'b0, 1'b0, '0, '0, 1'b1, acc);

    // ack during FILL is ignored
    step("fill_ack", 1'b1, 1'b1, 32'h60, 32'h70, 1'b0, acc);
    step("fill_ack", 1'b1, 1'b0, 32'h61, 32'h71, 1'b0, acc);
    step("fill_ack_pulse", 1'b0, 1'b0, '0, '0, 1'b1, acc);
    for (int k = 2; k < 8; k++) step("fill_ack_rest", 1'b1, 1'b0, 32'h60 + W'(k), 32'h70 + W'(k), 1'b0, acc);
    chk("fill_ack:fv", W'(frame_valid), W'(1));
    step("fill_ack_done", 1'b0, 1'b0, '0, '0, 1'b1, acc);

    // reset mid-frame
    for (int k = 0; k < 5; k++) step("pre_rst", 1'b1, k == 0, 32'h80 + W'(k), 32'h90 + W'(k), 1'b0, acc);
    apply_reset();
    for (int k = 0; k < 8; k++) step("post_rst", 1'b1, k == 0, 32'hC0 + W'(k), 32'hD0 + W'(k), 1'b0, acc);
    chk("post_rst:fv", W'(frame_valid), W'(1));
    step("post_rst_ack", 1'b0, 1'b0, '0, '0, 1'b1, acc);

    // random traffic: 4 frames, ~50% valid gaps, ack delays 0..3
    for (int k = 0; k < 64; k++) samples.push_back($urandom());
    sent = 0; frames_seen = 0; delay = 0; prev_fv = 1'b0; cyc = 0;
    while ((frames_seen < 4 || frame_valid) && cyc < 3000) begin
      bit ack;
      v   = (sent < 32) && ($urandom_range(0, 1) == 1);
      ack = m_full && (delay == 0);
      if (m_full && delay > 0) delay--;
      step("rand", v, m_cnt == 0, samples[2*sent], samples[2*sent+1], ack, acc);
      if (acc) sent++;
      if (frame_valid && !prev_fv) begin
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("rand_f%0d:bin%0dr", frames_seen, k), xr[slot_of[k]], samples[2*(frames_seen*8+k)]);
          chk($sformatf("rand_f%0d:bin%0di", frames_seen, k), xi[slot_of[k]], samples[2*(frames_seen*8+k)+1]);
        end
        frames_seen++;
        delay = $urandom_range(0, 3);
      end
      prev_fv = frame_valid;
      cyc++;
    end
    chk("rand:frames", W'(frames_seen), W'(4));
    chk("rand:samples_sent", W'(sent), W'(32));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
